// File: rtl/seg_scan_decoder.sv
// Rebuilds a two-digit number from a scanned COM/SEG bus. Optional macro SEGDEC_BLANK_LEADING_EN accepts a blank tens digit as 0.
// Publishes after STABLE_SCANS identical good frames, one cycle after the completing sample; no backpressure.
module seg_scan_decoder #(
   parameter int SETTLE_CYCLES  = 8,
   parameter int STABLE_SCANS   = 4,
   parameter int TIMEOUT_CYCLES = 65536
) (
   input  logic       Sys_CLK,
   input  logic       Sys_RST,
   input  logic [1:0] COM,
   input  logic [7:0] SEG,
   output logic [3:0] Ten,
   output logic [3:0] One,
   output logic       Dp_Ten,
   output logic       Dp_One,
   output logic [7:0] Num,
   output logic       Valid,
   output logic       Update,
   output logic       Err
);

   localparam logic [7:0]  SETTLE_LAST = 8'(SETTLE_CYCLES - 1);
   localparam logic [7:0]  SETTLE_MAX  = 8'(SETTLE_CYCLES);
   localparam logic [3:0]  MATCH_MAX   = 4'(STABLE_SCANS);
   localparam logic [31:0] TMO_MAX     = 32'(TIMEOUT_CYCLES);

   function automatic logic [4:0] f_decode(input logic [6:0] seg);
      logic [4:0] res;
      res = 5'b0_0000;
      case (seg)
         7'h3F: res = 5'b1_0000;
         7'h06: res = 5'b1_0001;
         7'h5B: res = 5'b1_0010;
         7'h4F: res = 5'b1_0011;
         7'h66: res = 5'b1_0100;
         7'h6D: res = 5'b1_0101;
         7'h7D: res = 5'b1_0110;
         7'h07: res = 5'b1_0111;
         7'h7F: res = 5'b1_1000;
         7'h6F: res = 5'b1_1001;
         default: res = 5'b0_0000;
      endcase
      return res;
   endfunction

   logic [1:0]  r_com_s1, r_com_s2, r_com_q;
   logic [7:0]  r_seg_s1, r_seg_s2;
   logic [7:0]  r_settle;
   logic        r_have_ten, r_have_one;
   logic [3:0]  r_ten, r_one;
   logic        r_dpt, r_dpo;
   logic [9:0]  r_last;
   logic [3:0]  r_match;
   logic [31:0] r_tmo;
   logic [3:0]  r_pub_ten, r_pub_one;
   logic        r_pub_dpt, r_pub_dpo;
   logic [7:0]  r_num;
   logic        r_valid, r_update, r_err;

   logic        w_com_stable, w_is_ten, w_is_one, w_both, w_sample;
   logic [4:0]  w_dec;
   logic        w_blank_ok, w_good, w_bad_smp, w_good_smp, w_closes, w_frame_done;
   logic [3:0]  w_digit, w_match_nxt;
   logic [9:0]  w_frame;
   logic [7:0]  w_num;
   logic        w_pub;

   assign w_com_stable = (r_com_s2 == r_com_q);
   assign w_is_ten     = (r_com_s2 == 2'b01);
   assign w_is_one     = (r_com_s2 == 2'b10);
   assign w_both       = (r_com_s2 == 2'b00);
   assign w_sample     = w_com_stable && (w_is_ten || w_is_one) && (r_settle == SETTLE_LAST);

   assign w_dec   = f_decode(r_seg_s2[6:0]);
   assign w_digit = w_dec[3:0];
`ifdef SEGDEC_BLANK_LEADING_EN
   assign w_blank_ok = w_is_ten && (r_seg_s2[6:0] == 7'h00);
`else
   assign w_blank_ok = 1'b0;
`endif
   assign w_good       = w_dec[4] | w_blank_ok;
   assign w_bad_smp    = w_sample && !w_good;
   assign w_good_smp   = w_sample && w_good;
   // A sample "closes" a frame when the other digit is already held, whether or not it decodes.
   assign w_closes     = w_sample && (w_is_ten ? r_have_one : r_have_ten);
   assign w_frame_done = w_good_smp && w_closes;

   assign w_frame = {(w_is_ten ? w_digit : r_ten),
                     (w_is_one ? w_digit : r_one),
                     (w_is_ten ? r_seg_s2[7] : r_dpt),
                     (w_is_one ? r_seg_s2[7] : r_dpo)};

   assign w_match_nxt = ((r_match != 4'd0) && (w_frame == r_last))
                      ? ((r_match == MATCH_MAX) ? MATCH_MAX : r_match + 4'd1)
                      : 4'd1;

   assign w_pub = w_frame_done && (w_match_nxt == MATCH_MAX) &&
                  ((w_frame != {r_pub_ten, r_pub_one, r_pub_dpt, r_pub_dpo}) || !r_valid);

   assign w_num = ({4'd0, w_frame[9:6]} << 3) + ({4'd0, w_frame[9:6]} << 1) + {4'd0, w_frame[5:2]};

   always_ff @(posedge Sys_CLK or negedge Sys_RST) begin
      if (!Sys_RST) begin
         r_com_s1   <= 2'b11;
         r_com_s2   <= 2'b11;
         r_com_q    <= 2'b11;
         r_seg_s1   <= 8'h00;
         r_seg_s2   <= 8'h00;
         r_settle   <= 8'd0;
         r_have_ten <= 1'b0;
         r_have_one <= 1'b0;
         r_ten      <= 4'd0;
         r_one      <= 4'd0;
         r_dpt      <= 1'b0;
         r_dpo      <= 1'b0;
         r_last     <= 10'd0;
         r_match    <= 4'd0;
         r_tmo      <= 32'd0;
         r_pub_ten  <= 4'd0;
         r_pub_one  <= 4'd0;
         r_pub_dpt  <= 1'b0;
         r_pub_dpo  <= 1'b0;
         r_num      <= 8'd0;
         r_valid    <= 1'b0;
         r_update   <= 1'b0;
         r_err      <= 1'b0;
      end else begin
         r_com_s1 <= COM;
         r_com_s2 <= r_com_s1;
         r_com_q  <= r_com_s2;
         r_seg_s1 <= SEG;
         r_seg_s2 <= r_seg_s1;

         // Saturating at SETTLE_CYCLES guarantees SETTLE_LAST is passed once per phase.
         if (!w_com_stable || (r_com_s2 == 2'b11))
            r_settle <= 8'd0;
         else if (!w_both && (r_settle != SETTLE_MAX))
            r_settle <= r_settle + 8'd1;

         if (w_both || w_bad_smp || w_frame_done) begin
            r_have_ten <= 1'b0;
            r_have_one <= 1'b0;
         end else if (w_good_smp && w_is_ten) begin
            r_have_ten <= 1'b1;
            r_ten      <= w_digit;
            r_dpt      <= r_seg_s2[7];
         end else if (w_good_smp) begin
            r_have_one <= 1'b1;
            r_one      <= w_digit;
            r_dpo      <= r_seg_s2[7];
         end

         if (w_bad_smp)
            r_match <= 4'd0;
         else if (w_frame_done) begin
            r_match <= w_match_nxt;
            r_last  <= w_frame;
         end

         if (w_both || w_bad_smp)
            r_err <= 1'b1;
         else if (w_frame_done)
            r_err <= 1'b0;

         if (w_closes)
            r_tmo <= 32'd0;
         else if (r_tmo != TMO_MAX)
            r_tmo <= r_tmo + 32'd1;

         if (w_pub)
            r_valid <= 1'b1;
         else if (r_tmo == TMO_MAX)
            r_valid <= 1'b0;

         r_update <= w_pub;
         if (w_pub) begin
            r_pub_ten <= w_frame[9:6];
            r_pub_one <= w_frame[5:2];
            r_pub_dpt <= w_frame[1];
            r_pub_dpo <= w_frame[0];
            r_num     <= w_num;
         end
      end
   end

   assign Ten    = r_pub_ten;
   assign One    = r_pub_one;
   assign Dp_Ten = r_pub_dpt;
   assign Dp_One = r_pub_dpo;
   assign Num    = r_num;
   assign Valid  = r_valid;
   assign Update = r_update;
   assign Err    = r_err;

endmodule

// File: tb/tb_seg_scan_decoder.sv
// Directed bench for seg_scan_decoder: scans digit patterns and checks publish, filter, timeout, error and reset behaviour.
module tb_seg_scan_decoder;

   logic       Sys_CLK = 1'b0;
   logic       Sys_RST = 1'b0;
   logic [1:0] COM = 2'b11;
   logic [7:0] SEG = 8'h00;
   logic [3:0] Ten, One;
   logic       Dp_Ten, Dp_One;
   logic [7:0] Num;
   logic       Valid, Update, Err;

   int n_tests = 0;
   int n_fail  = 0;
   int n_upd   = 0;
   int upd_base;

   seg_scan_decoder dut (
      .Sys_CLK(Sys_CLK), .Sys_RST(Sys_RST), .COM(COM), .SEG(SEG),
      .Ten(Ten), .One(One), .Dp_Ten(Dp_Ten), .Dp_One(Dp_One),
      .Num(Num), .Valid(Valid), .Update(Update), .Err(Err)
   );

   always #10 Sys_CLK = ~Sys_CLK;

   always @(negedge Sys_CLK) if (Update === 1'b1) n_upd++;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   task automatic phase(input logic [1:0] c, input logic [7:0] s, input int n);
      COM = c;
      SEG = s;
      repeat (n) @(negedge Sys_CLK);
   endtask

   task automatic frame(input logic [7:0] tens, input logic [7:0] ones);
      phase(2'b01, tens, 50);
      phase(2'b10, ones, 50);
   endtask

   initial begin
      repeat (3) @(negedge Sys_CLK);
      chk("rst_num", Num, 0);
      chk("rst_valid", Valid, 0);
      chk("rst_err", Err, 0);
      Sys_RST = 1'b1;
      @(negedge Sys_CLK);

      // "06" with tens dp lit
      upd_base = n_upd;
      repeat (3) frame(8'hBF, 8'h7D);
      chk("06_noupd_3", n_upd - upd_base, 0);
      chk("06_valid_3", Valid, 0);
      frame(8'hBF, 8'h7D);
      chk("06_upd_4", n_upd - upd_base, 1);
      chk("06_ten", Ten, 0);
      chk("06_one", One, 6);
      chk("06_dpt", Dp_Ten, 1);
      chk("06_dpo", Dp_One, 0);
      chk("06_num", Num, 6);
      chk("06_valid", Valid, 1);
      repeat (2) frame(8'hBF, 8'h7D);
      chk("06_noreupd", n_upd - upd_base, 1);

      // three "05" frames then back to "06": filter rejects
      upd_base = n_upd;
      repeat (3) frame(8'hBF, 8'h6D);
      frame(8'hBF, 8'h7D);
      chk("05x3_noupd", n_upd - upd_base, 0);
      chk("05x3_num", Num, 6);
      repeat (4) frame(8'hBF, 8'h6D);
      chk("05x4_upd", n_upd - upd_base, 1);
      chk("05x4_num", Num, 5);

      // fast COM toggling: no samples, timeout drops Valid
      upd_base = n_upd;
      for (int i = 0; i < 7500; i++) begin
         phase(2'b01, 8'hBF, 4);
         phase(2'b10, 8'h6D, 4);
      end
      chk("tmo_valid_early", Valid, 1);
      for (int i = 0; i < 750; i++) begin
         phase(2'b01, 8'hBF, 4);
         phase(2'b10, 8'h6D, 4);
      end
      chk("tmo_valid_low", Valid, 0);
      chk("tmo_num_hold", Num, 5);
      chk("tmo_noupd", n_upd - upd_base, 0);

      // bad ones pattern, then recovery needs 4 good frames
      upd_base = n_upd;
      phase(2'b10, 8'h49, 50);
      chk("bad_err", Err, 1);
      chk("bad_num_hold", Num, 5);
      frame(8'hBF, 8'h6D);
      chk("bad_err_clr", Err, 0);
      repeat (2) frame(8'hBF, 8'h6D);
      chk("bad_noupd_3", n_upd - upd_base, 0);
      chk("bad_valid_3", Valid, 0);
      frame(8'hBF, 8'h6D);
      chk("bad_upd_4", n_upd - upd_base, 1);
      chk("bad_valid_4", Valid, 1);

      // both digits selected
      upd_base = n_upd;
      phase(2'b00, 8'h6D, 50);
      chk("both_err", Err, 1);
      chk("both_num_hold", Num, 5);
      frame(8'hBF, 8'h6D);
      chk("both_err_clr", Err, 0);
      chk("both_noupd", n_upd - upd_base, 0);

      // async reset after only the tens sample
      phase(2'b01, 8'hBF, 50);
      #3 Sys_RST = 1'b0;
      #1;
      chk("arst_num", Num, 0);
      chk("arst_dpt", Dp_Ten, 0);
      chk("arst_valid", Valid, 0);
      repeat (3) @(negedge Sys_CLK);
      Sys_RST = 1'b1;
      upd_base = n_upd;
      repeat (3) frame(8'hBF, 8'h7D);
      chk("arst_noupd_3", n_upd - upd_base, 0);
      frame(8'hBF, 8'h7D);
      chk("arst_upd_4", n_upd - upd_base, 1);
      chk("arst_num_6", Num, 6);

      // blank tens digit
      Sys_RST = 1'b0;
      repeat (2) @(negedge Sys_CLK);
      Sys_RST = 1'b1;
      repeat (4) frame(8'h00, 8'h4F);
`ifdef SEGDEC_BLANK_LEADING_EN
      chk("blank_num", Num, 3);
      chk("blank_valid", Valid, 1);
      chk("blank_err", Err, 0);
`else
      chk("blank_err", Err, 1);
      chk("blank_valid", Valid, 0);
      chk("blank_num", Num, 0);
`endif

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
